// File: rtl/seven_seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner with a memory-mapped register file.
// Each slot blanks all digits, then shows one hex-decoded digit; digits are visited round-robin.
module seven_seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned DIG_ACTIVE_LOW = 1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       WrEn,
   input  logic [2:0] Addr,
   input  logic [7:0] WrData,
   output logic [7:0] RdData,
   output logic [7:0] Segment,
   output logic [5:0] Digital,
   output logic [2:0] ScanIdx,
   output logic       FrameTick
);

   localparam int unsigned CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned NUM_DIG   = 6;
   localparam int unsigned DREG_W    = 6;
   localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIG - 1);
   localparam logic [2:0]  CTRL_ADDR = 3'(NUM_DIG);
   localparam logic [7:0]  SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [5:0]  DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         idx_q, idx_d;
   logic               frame_q, frame_d;
   logic [7:0]         shadow_q, shadow_d;
   logic [7:0]         seg_q, seg_d;
   logic [5:0]         dig_q, dig_d;
   logic [DREG_W-1:0]  dreg_q [NUM_DIG];
   logic [DREG_W-1:0]  dreg_d [NUM_DIG];
   logic               ctrl_q, ctrl_d;
   logic               unused_wr_bits;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Active-high lit pattern for a digit register; blank kills dp too.
   function automatic logic [7:0] lit_pattern(input logic [DREG_W-1:0] r);
      return r[5] ? 8'h00 : {r[4], hex7(r[3:0])};
   endfunction

   assign unused_wr_bits = ^WrData[7:6];

   // Register file write path
   always_comb begin
      ctrl_d = ctrl_q;
      for (int i = 0; i < NUM_DIG; i++) dreg_d[i] = dreg_q[i];
      if (WrEn) begin
         if (Addr < CTRL_ADDR) dreg_d[Addr] = WrData[DREG_W-1:0];
         else if (Addr == CTRL_ADDR) ctrl_d = WrData[0];
      end
   end

   // Combinational readback
   always_comb begin
      RdData = 8'h00;
      if (Addr < CTRL_ADDR) RdData = {2'b00, dreg_q[Addr]};
      else if (Addr == CTRL_ADDR) RdData = {7'b0, ctrl_q};
   end

   // Scan FSM next-state and registered pin values
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      frame_d  = 1'b0;
      seg_d    = SEG_OFF;
      dig_d    = DIG_OFF;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            idx_d = 3'd0;
            if (ctrl_q) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            if (!ctrl_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == BLANK_LAST) begin
                  shadow_d = lit_pattern(dreg_q[idx_q]);
                  state_d  = ST_SHOW;
               end
            end
         end
         ST_SHOW: begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~shadow_q : shadow_q;
            dig_d = (DIG_ACTIVE_LOW != 0) ? ~(6'b1 << idx_q) : (6'b1 << idx_q);
            if (!ctrl_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end else if (cnt_q == SLOT_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
               frame_d = (idx_q == LAST_IDX);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         frame_q  <= 1'b0;
         shadow_q <= 8'h00;
         seg_q    <= SEG_OFF;
         dig_q    <= DIG_OFF;
         ctrl_q   <= 1'b0;
         for (int i = 0; i < NUM_DIG; i++) dreg_q[i] <= 6'h20;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         frame_q  <= frame_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         dig_q    <= dig_d;
         ctrl_q   <= ctrl_d;
         for (int i = 0; i < NUM_DIG; i++) dreg_q[i] <= dreg_d[i];
      end
   end

   assign Segment   = seg_q;
   assign Digital   = dig_q;
   assign ScanIdx   = idx_q;
   assign FrameTick = frame_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-shares the board's single 8-bit segment bus between the six digit enables on the Segment/Digital pins.
- A software-visible register file holds one entry per digit; the block hex-decodes each entry and scans the digits round-robin.
- A blanking gap separates consecutive digits to prevent ghosting.
- Sits inside SystemChip as a memory-mapped I/O peripheral, driving Segment[7:0] and Digital[5:0] directly.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (blank + show). At 20 ns this is 1 ms.
- BLANK_CYCLES, 500: cycles per slot with all digits off. Legal range is 1 to SCAN_DIV-1.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when the pin is 0.
- DIG_ACTIVE_LOW, 1: 1 = digit selected when the pin is 0.

Ports:
- Clock  in  1  system clock; all state on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WrEn  in  1  register write strobe, one cycle.
- Addr  in  3  register address.
- WrData  in  8  write data.
- RdData  out  8  combinational readback of register[Addr].
- Segment  out  8  bits [6:0] = segments a..g, bit 7 = dp; registered.
- Digital  out  6  digit enables, bit k = digit k; registered.
- ScanIdx  out  3  digit currently in its slot, 0..5; registered.
- FrameTick  out  1  one-cycle pulse when ScanIdx wraps 5→0.

Behaviour:
- Register map:
  - Addr 0..5 are digit regs: [3:0] hex value, [4] dp, [5] blank, [7:6] read as 0.
  - Addr 6 is CTRL: [0] Enable, others read as 0.
  - Addr 7: writes ignored, reads 0.
- Register writes take effect on the edge where WrEn=1.
- Reset values:
  - Digit regs = 0x20 (blanked); CTRL = 0.
  - State IDLE, ScanIdx = 0, FrameTick = 0.
  - Segment and Digital at their inactive level. With default polarity, Segment = 8'hFF and Digital = 6'h3F.
- Asynchronous reset mid-scan forces all of the above immediately.
- Decode is active-high before the polarity inversion:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Bit 7 = dp. If blank=1, all segments including dp are off.
- One slot counter runs 0..SCAN_DIV-1.
- FSM states:
  - IDLE: outputs inactive; counter and ScanIdx held at 0. Goes to BLANK the cycle after Enable is seen as 1.
  - BLANK: Digital and Segment inactive for BLANK_CYCLES cycles, then SHOW. On the last BLANK cycle, digit reg[ScanIdx] is latched into a shadow pattern.
  - SHOW: Digital drives only bit ScanIdx active and Segment drives the shadow pattern, for SCAN_DIV-BLANK_CYCLES cycles. Then ScanIdx advances (5 wraps to 0) and the FSM returns to BLANK.
- Outputs are registered: pin changes appear one cycle after the state change.
- FrameTick is asserted for exactly the cycle in which ScanIdx changes 5→0.
- A write to the digit currently shown does not alter the pins until that digit's next slot (no tearing).
- Enable cleared during BLANK or SHOW:
  - FSM returns to IDLE on the next edge; pins go inactive one cycle later.
  - ScanIdx resets to 0; FrameTick is not generated.
- Enable written 1 while already enabled: no effect on scan timing.
- At most one digit enable is active at any time; never an active digit during BLANK.

Test Plan:
Use SCAN_DIV=10, BLANK_CYCLES=2 and default polarity throughout.
- Reset: assert Reset=0 mid-run → Segment=FF, Digital=3F, ScanIdx=0 immediately; RdData at Addr 0..5 = 0x20, Addr 6 = 0x00.
- Basic scan: write regs 0..5 = 0x01,0x02,0x03,0x04,0x05,0x1F, then CTRL=0x01.
  - Digital cycles 3E,3D,3B,37,2F,1F, each active 8 cycles, separated by 2 cycles of 3F.
  - Segment for digit 0 = F9; digit 5 = 0E (F with dp lit).
  - FrameTick pulses every 60 cycles.
- Blank bit: reg 2 = 0x27 → during digit 2's slot Digital=3B and Segment=FF.
- No tearing: while digit 1 is in SHOW, write reg 1 = 0x08 → Segment stays A4 (digit 2) until the slot ends; the next visit to digit 1 shows 80.
- Disable mid-SHOW: write CTRL=0 at cycle 4 of digit 3's slot → within 2 cycles Segment=FF, Digital=3F, ScanIdx=0; re-enable starts with a BLANK slot for digit 0.
- Addr 7 and reserved bits: write Addr 7 = 0xFF and reg 0 = 0xFF → RdData at Addr 7 = 00, reg 0 = 0x3F, scan timing unchanged.
